// File: rtl/inst_encoder_loader_if.sv
// Bundle for the instruction-loader: field-beat stream in, instruction-memory
// write port and session status out.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        in_opcode;
  logic [5:0]        in_funct;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err_illegal;
  logic              err_overflow;

  modport master (
    output start, in_valid, in_last, in_opcode, in_funct, in_rs, in_rt, in_rd,
           in_shamt, in_imm, in_target,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, count,
           err_illegal, err_overflow
  );

  modport slave (
    input  start, in_valid, in_last, in_opcode, in_funct, in_rs, in_rt, in_rd,
           in_shamt, in_imm, in_target,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, count,
           err_illegal, err_overflow
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Encodes structured MIPS instruction fields into 32-bit words and writes them
// sequentially into instruction memory ahead of CPU release.
//
//   state | meaning
//   Idle  | no session, stream stalled
//   Load  | accepting beats, one memory write per legal beat
//   Done  | session ended (in_last, memory full); held until next start
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input logic                  clk,
  input logic                  reset,
  inst_encoder_loader_if.slave bus
);
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {Idle, Load, Done} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] nextAddr;
  logic              accept;
  logic              legal;
  logic              atLast;
  logic              shiftFn;
  logic [4:0]        rsF, rtF, rdF, shF;
  logic [31:0]       encoded;

  // A beat coinciding with start is refused so the restart is clean.
  assign bus.in_ready = (state == Load) && !bus.start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign atLast       = (nextAddr == LastAddr);
  assign bus.busy     = (state == Load);
  assign bus.done     = (state == Done);

  always_comb begin
    legal = 1'b0;
    case (bus.in_opcode)
      6'h00: begin
        case (bus.in_funct)
          6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: legal = 1'b1;
          default:                                  legal = 1'b0;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f,
      6'h23, 6'h2b: legal = 1'b1;
      default:      legal = 1'b0;
    endcase
  end

  always_comb begin
    shiftFn = (bus.in_funct == 6'h00) || (bus.in_funct == 6'h02) ||
              (bus.in_funct == 6'h03);
    rsF     = bus.in_rs;
    rtF     = bus.in_rt;
    rdF     = bus.in_rd;
    shF     = 5'd0;
    if (bus.in_opcode == 6'h0f) rsF = 5'd0;
    if (bus.in_opcode == 6'h00) begin
      if (shiftFn) begin
        rsF = 5'd0;
        shF = bus.in_shamt;
      end
      if (bus.in_funct == 6'h08) begin
        rtF = 5'd0;
        rdF = 5'd0;
      end
      if (bus.in_funct == 6'h09) rtF = 5'd0;
    end
    encoded = {bus.in_opcode, rsF, rtF, bus.in_imm};
    if (bus.in_opcode == 6'h00)
      encoded = {bus.in_opcode, rsF, rtF, rdF, shF, bus.in_funct};
    else if ((bus.in_opcode == 6'h02) || (bus.in_opcode == 6'h03))
      encoded = {bus.in_opcode, bus.in_target};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= Idle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      Idle: if (bus.start) stateNext = Load;
      Load: begin
        if (bus.start)
          stateNext = Load;
        else if (accept && (bus.in_last || (legal && atLast)))
          stateNext = Done;
      end
      Done: if (bus.start) stateNext = Load;
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nextAddr         <= BaseAddr;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.count        <= '0;
      bus.err_illegal  <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.start) begin
        nextAddr         <= BaseAddr;
        bus.count        <= '0;
        bus.err_illegal  <= 1'b0;
        bus.err_overflow <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= nextAddr;
          bus.mem_wdata <= encoded;
          bus.count     <= bus.count + 1'b1;
          // The top address is terminal: no wrap, overflow if program continues.
          if (!atLast)           nextAddr         <= nextAddr + 1'b1;
          else if (!bus.in_last) bus.err_overflow <= 1'b1;
        end else begin
          bus.err_illegal <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader with a behavioural session model
// checked every cycle plus literal expectations per scenario.
module tb_inst_encoder_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_encoder_loader_if #(.ADDR_W(AW)) bus ();
  inst_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int nAssert = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  int unsigned legalOps[12] = '{'h00, 'h02, 'h03, 'h04, 'h08, 'h09, 'h0a, 'h0b,
                                'h0c, 'h0f, 'h23, 'h2b};
  int unsigned legalFns[15] = '{'h00, 'h02, 'h03, 'h08, 'h09, 'h20, 'h21, 'h22,
                                'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b};

  // Model session: phase 0 idle, 1 loading, 2 finished.
  int          mPhase = 0, mNext = 0, mCount = 0;
  bit          mWe = 0, mErrI = 0, mErrO = 0;
  int unsigned mAddr = 0, mWdata = 0;

  int unsigned logAddr[$];
  int unsigned logData[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelLegal(input int unsigned op, input int unsigned fn);
    bit okOp = 1'b0;
    bit okFn = 1'b0;
    foreach (legalOps[i]) if (legalOps[i] == op) okOp = 1'b1;
    foreach (legalFns[i]) if (legalFns[i] == fn) okFn = 1'b1;
    return (op == 0) ? okFn : okOp;
  endfunction

  function automatic int unsigned modelEncode(input int unsigned op, fn, rs, rt, rd, sh,
                                              imm, tgt);
    bit isShift = (fn == 0) || (fn == 2) || (fn == 3);
    if (op == 2 || op == 3) return op * (1 << 26) + tgt;
    if (op != 0) return op * (1 << 26) + ((op == 'h0f) ? 0 : rs) * (1 << 21) +
                        rt * (1 << 16) + imm;
    return (isShift ? 0 : rs) * (1 << 21) + ((fn == 8 || fn == 9) ? 0 : rt) * (1 << 16) +
           ((fn == 8) ? 0 : rd) * (1 << 11) + (isShift ? sh : 0) * 64 + fn;
  endfunction

  always @(posedge clk) begin : model
    int ph, nx, cn;
    bit we, ei, eo;
    int unsigned ad, wd;
    ph = mPhase; nx = mNext; cn = mCount; we = 1'b0; ei = mErrI; eo = mErrO;
    ad = mAddr; wd = mWdata;
    if (reset) begin
      ph = 0; nx = 0; cn = 0; ei = 0; eo = 0; ad = 0; wd = 0;
    end else if (bus.start) begin
      ph = 1; nx = 0; cn = 0; ei = 0; eo = 0;
    end else if (ph == 1 && bus.in_valid) begin
      if (!modelLegal(32'(bus.in_opcode), 32'(bus.in_funct))) begin
        ei = 1;
        if (bus.in_last) ph = 2;
      end else begin
        we = 1; ad = nx; cn++; nx++;
        wd = modelEncode(32'(bus.in_opcode), 32'(bus.in_funct), 32'(bus.in_rs),
                         32'(bus.in_rt), 32'(bus.in_rd), 32'(bus.in_shamt),
                         32'(bus.in_imm), 32'(bus.in_target));
        if (nx == DEPTH) begin
          ph = 2;
          if (!bus.in_last) eo = 1;
        end else if (bus.in_last) ph = 2;
      end
    end
    mPhase <= ph; mNext <= nx; mCount <= cn; mWe <= we; mErrI <= ei; mErrO <= eo;
    mAddr <= ad; mWdata <= wd;
  end

  always @(negedge clk) begin
    if (checkEn) begin
      chk("in_ready", 32'(bus.in_ready), 32'(mPhase == 1 && !bus.start));
      chk("busy", 32'(bus.busy), 32'(mPhase == 1));
      chk("done", 32'(bus.done), 32'(mPhase == 2));
      chk("mem_we", 32'(bus.mem_we), 32'(mWe));
      if (mWe) chk("mem_addr", 32'(bus.mem_addr), mAddr);
      chk("mem_wdata", bus.mem_wdata, mWdata);
      chk("count", 32'(bus.count), 32'(mCount));
      chk("err_illegal", 32'(bus.err_illegal), 32'(mErrI));
      chk("err_overflow", 32'(bus.err_overflow), 32'(mErrO));
    end
    if (bus.mem_we === 1'b1) begin
      logAddr.push_back(32'(bus.mem_addr));
      logData.push_back(bus.mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  task automatic setBeat(input int unsigned op, fn, rs, rt, rd, sh, imm, tgt, input bit last);
    bus.in_opcode = 6'(op);  bus.in_funct = 6'(fn);
    bus.in_rs     = 5'(rs);  bus.in_rt    = 5'(rt);
    bus.in_rd     = 5'(rd);  bus.in_shamt = 5'(sh);
    bus.in_imm    = 16'(imm); bus.in_target = 26'(tgt);
    bus.in_last   = last;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic sendBeat(input int unsigned op, fn, rs, rt, rd, sh, imm, tgt,
                          input bit last, input int maxWait, output bit acc);
    setBeat(op, fn, rs, rt, rd, sh, imm, tgt, last);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < maxWait && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic startPulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int unsigned t4Data[4] = '{32'h3C03ABCD, 32'h03E00008, 32'h0080F809, 32'h1022FFFE};
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    setBeat(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    checkEn = 1'b1;
    tick();
    reset = 1'b0;

    chk("rstCount", 32'(bus.count), 0);
    chk("rstReady", 32'(bus.in_ready), 0);
    chk("rstWe", 32'(bus.mem_we), 0);
    chk("mdlAdd", modelEncode('h00, 'h20, 8, 9, 10, 3, 0, 0), 32'h01095020);
    chk("mdlSll", modelEncode('h00, 'h00, 5, 9, 8, 2, 0, 0), 32'h00094080);
    chk("mdlIllegal", 32'(modelLegal('h3f, 0)), 0);

    // add $10,$8,$9
    startPulse();
    clearLog();
    sendBeat('h00, 'h20, 8, 9, 10, 3, 0, 0, 1'b0, 4, acc);
    chk("t1Acc", 32'(acc), 1);
    chk("t1We", 32'(bus.mem_we), 1);
    chk("t1Addr", 32'(bus.mem_addr), 0);
    chk("t1Data", bus.mem_wdata, 32'h01095020);
    chk("t1Count", 32'(bus.count), 1);

    // lw, jal, sll back-to-back
    startPulse();
    clearLog();
    sendBeat('h23, 0, 29, 8, 0, 0, 'h0004, 0, 1'b0, 4, acc);
    sendBeat('h03, 0, 0, 0, 0, 0, 0, 'h0100000, 1'b0, 4, acc);
    sendBeat('h00, 'h00, 5, 9, 8, 2, 0, 0, 1'b1, 4, acc);
    chk("t2Done", 32'(bus.done), 1);
    chk("t2Ready", 32'(bus.in_ready), 0);
    tick();
    chk("t2Writes", logAddr.size(), 3);
    if (logAddr.size() == 3) begin
      chk("t2Lw", logData[0], 32'h8FA80004);
      chk("t2Jal", logData[1], 32'h0C100000);
      chk("t2Sll", logData[2], 32'h00094080);
      chk("t2Addr2", logAddr[2], 2);
    end

    // illegal opcode then legal, then illegal funct with last
    startPulse();
    clearLog();
    sendBeat('h3f, 0, 1, 2, 3, 0, 'h5555, 0, 1'b0, 4, acc);
    sendBeat('h09, 0, 1, 2, 0, 0, 'h1234, 0, 1'b0, 4, acc);
    chk("t3ErrI", 32'(bus.err_illegal), 1);
    tick();
    chk("t3Writes", logAddr.size(), 1);
    if (logAddr.size() == 1) begin
      chk("t3Addr", logAddr[0], 0);
      chk("t3Data", logData[0], 32'h24221234);
    end
    sendBeat('h00, 'h3f, 1, 2, 3, 0, 0, 0, 1'b1, 4, acc);
    chk("t3Done", 32'(bus.done), 1);
    chk("t3Count", 32'(bus.count), 1);
    tick();
    chk("t3NoWrite", logAddr.size(), 1);

    // overflow: four beats without in_last fill the 4-word memory
    startPulse();
    clearLog();
    sendBeat('h0f, 0, 7, 3, 0, 0, 'hABCD, 0, 1'b0, 4, acc);
    sendBeat('h00, 'h08, 31, 5, 6, 4, 0, 0, 1'b0, 4, acc);
    sendBeat('h00, 'h09, 4, 7, 31, 1, 0, 0, 1'b0, 4, acc);
    sendBeat('h04, 0, 1, 2, 0, 0, 'hFFFE, 0, 1'b0, 4, acc);
    chk("t4Done", 32'(bus.done), 1);
    chk("t4ErrO", 32'(bus.err_overflow), 1);
    chk("t4Count", 32'(bus.count), 4);
    sendBeat('h08, 0, 1, 1, 0, 0, 1, 0, 1'b0, 3, acc);
    chk("t4FifthRefused", 32'(acc), 0);
    tick();
    chk("t4Writes", logAddr.size(), 4);
    if (logAddr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4Addr", logAddr[i], 32'(i));
        chk("t4Data", logData[i], t4Data[i]);
      end
    end

    // restart mid-LOAD with a beat held across start
    startPulse();
    sendBeat('h3f, 0, 0, 0, 0, 0, 0, 0, 1'b0, 4, acc);
    sendBeat('h2b, 0, 29, 31, 0, 0, 'h0008, 0, 1'b0, 4, acc);
    sendBeat('h00, 'h2a, 1, 2, 3, 5, 0, 0, 1'b0, 4, acc);
    tick();
    chk("t5PreCount", 32'(bus.count), 2);
    chk("t5PreErrI", 32'(bus.err_illegal), 1);
    clearLog();
    setBeat('h0a, 0, 2, 3, 0, 0, 7, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5Count0", 32'(bus.count), 0);
    chk("t5ErrClr", 32'(bus.err_illegal), 0);
    chk("t5NoWe", 32'(bus.mem_we), 0);
    tick();
    bus.in_valid = 1'b0;
    chk("t5We", 32'(bus.mem_we), 1);
    chk("t5Addr", 32'(bus.mem_addr), 0);
    chk("t5Data", bus.mem_wdata, 32'h28430007);
    chk("t5Count1", 32'(bus.count), 1);

    // reset mid-LOAD
    sendBeat('h0c, 0, 4, 5, 0, 0, 'h00FF, 0, 1'b0, 4, acc);
    tick();
    clearLog();
    reset = 1'b1;
    setBeat('h08, 0, 1, 2, 0, 0, 5, 0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6We", 32'(bus.mem_we), 0);
    chk("t6Addr", 32'(bus.mem_addr), 0);
    chk("t6Data", bus.mem_wdata, 0);
    chk("t6Count", 32'(bus.count), 0);
    chk("t6Busy", 32'(bus.busy), 0);
    chk("t6Ready", 32'(bus.in_ready), 0);
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("t6NoWrites", logAddr.size(), 0);
    startPulse();
    sendBeat('h08, 0, 1, 2, 0, 0, 5, 0, 1'b1, 4, acc);
    chk("t6ReAddr", 32'(bus.mem_addr), 0);
    chk("t6ReData", bus.mem_wdata, 32'h20220005);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
